// File: rtl/spi_master_tx.sv
// spi_master_tx: SPI initiator that sends one register-access frame (control, address, data) per command.
module spi_master_tx #(
    parameter int CLK_DIV = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        cmd_start,
    input  logic        cmd_wrn,
    input  logic [3:0]  cmd_select,
    input  logic [18:0] cmd_address,
    input  logic [31:0] cmd_wdata,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] rdata,
    output logic        sclk,
    output logic        nss,
    output logic        mosi,
    input  logic        miso
);
    localparam logic [3:0] WB_FULL_WORD       = 4'b1111;
    localparam logic [3:0] WB_UPPER_HALF_WORD = 4'b1100;
    localparam logic [3:0] WB_LOWER_HALF_WORD = 4'b0011;
    localparam logic [3:0] WB_BYTE_0          = 4'b0001;
    localparam logic [3:0] WB_BYTE_1          = 4'b0010;
    localparam logic [3:0] WB_BYTE_2          = 4'b0100;
    localparam logic [3:0] WB_BYTE_3          = 4'b1000;
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;
    localparam logic [7:0] PRE_MAX = 8'(CLK_DIV - 1);

    logic [2:0]  state_q, state_d;
    logic [7:0]  pre_q, pre_d;
    logic [5:0]  bit_q, bit_d;
    logic [63:0] tx_q, tx_d;
    logic [31:0] rx_q, rx_d, rdata_q, rdata_d;
    logic [3:0]  sel_q, sel_d;
    logic        wrn_q, wrn_d, busy_q, busy_d, done_q, done_d, error_q, error_d;
    logic        sclk_q, sclk_d, nss_q, nss_d, mosi_q, mosi_d;
    logic        legal, tick;
    logic [5:0]  last;
    logic [31:0] lane_tx, lane_rx;

    assign legal = cmd_select inside {WB_FULL_WORD, WB_UPPER_HALF_WORD, WB_LOWER_HALF_WORD,
                                      WB_BYTE_0, WB_BYTE_1, WB_BYTE_2, WB_BYTE_3};
    assign tick  = pre_q == PRE_MAX;
    assign last  = sel_q == WB_FULL_WORD ? 6'd63 :
                   (sel_q == WB_UPPER_HALF_WORD || sel_q == WB_LOWER_HALF_WORD) ? 6'd47 : 6'd39;

    // Write lane is left-aligned so its MSB follows the address bytes directly.
    always_comb begin
        lane_tx = '0;
        case (cmd_select)
            WB_FULL_WORD:       lane_tx = cmd_wdata;
            WB_UPPER_HALF_WORD: lane_tx = {cmd_wdata[31:16], 16'h0};
            WB_LOWER_HALF_WORD: lane_tx = {cmd_wdata[15:0], 16'h0};
            WB_BYTE_0:          lane_tx = {cmd_wdata[7:0], 24'h0};
            WB_BYTE_1:          lane_tx = {cmd_wdata[15:8], 24'h0};
            WB_BYTE_2:          lane_tx = {cmd_wdata[23:16], 24'h0};
            WB_BYTE_3:          lane_tx = {cmd_wdata[31:24], 24'h0};
            default:            lane_tx = '0;
        endcase
    end

    always_comb begin
        lane_rx = '0;
        case (sel_q)
            WB_FULL_WORD:       lane_rx = rx_q;
            WB_UPPER_HALF_WORD: lane_rx = {rx_q[15:0], 16'h0};
            WB_LOWER_HALF_WORD: lane_rx = {16'h0, rx_q[15:0]};
            WB_BYTE_1:          lane_rx = {16'h0, rx_q[7:0], 8'h0};
            WB_BYTE_2:          lane_rx = {8'h0, rx_q[7:0], 16'h0};
            WB_BYTE_3:          lane_rx = {rx_q[7:0], 24'h0};
            default:            lane_rx = {24'h0, rx_q[7:0]};
        endcase
    end

    always_comb begin
        state_d = state_q;
        pre_d   = state_q == S_IDLE ? pre_q : (tick ? 8'd0 : pre_q + 8'd1);
        bit_d   = bit_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        rdata_d = rdata_q;
        sel_d   = sel_q;
        wrn_d   = wrn_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        error_d = 1'b0;
        sclk_d  = sclk_q;
        nss_d   = nss_q;
        mosi_d  = mosi_q;
        case (state_q)
            S_IDLE: if (cmd_start) begin
                if (legal) begin
                    state_d = S_SETUP;
                    bit_d   = '0;
                    sel_d   = cmd_select;
                    wrn_d   = cmd_wrn;
                    tx_d    = {cmd_wrn, cmd_select, cmd_address, cmd_wrn ? {lane_tx, 8'h00} : 40'h0};
                    mosi_d  = cmd_wrn;
                    busy_d  = 1'b1;
                    nss_d   = 1'b0;
                end else error_d = 1'b1;
            end
            S_SETUP: if (tick) state_d = S_SHIFT;
            S_SHIFT: if (tick) begin
                sclk_d = !sclk_q;
                if (sclk_q) begin
                    // Read data occupies the falling edges ending bits 31 .. last-1.
                    if (!wrn_q && bit_q >= 6'd31 && bit_q != last) rx_d = {rx_q[30:0], miso};
                    if (bit_q == last) begin
                        state_d = S_HOLD;
                        mosi_d  = 1'b0;
                    end else begin
                        bit_d  = bit_q + 6'd1;
                        tx_d   = tx_q << 1;
                        mosi_d = tx_q[62];
                    end
                end
            end
            S_HOLD: if (tick) begin
                state_d = S_GAP;
                nss_d   = 1'b1;
                bit_d   = '0;
            end
            S_GAP: if (tick) begin
                if (bit_q[0]) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    rdata_d = wrn_q ? rdata_q : lane_rx;
                end else bit_d = 6'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= S_IDLE;
            pre_q   <= '0;
            bit_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            rdata_q <= '0;
            sel_q   <= '0;
            wrn_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            sclk_q  <= 1'b0;
            nss_q   <= 1'b1;
            mosi_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            rdata_q <= rdata_d;
            sel_q   <= sel_d;
            wrn_q   <= wrn_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
            sclk_q  <= sclk_d;
            nss_q   <= nss_d;
            mosi_q  <= mosi_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign error = error_q;
    assign rdata = rdata_q;
    assign sclk  = sclk_q;
    assign nss   = nss_q;
    assign mosi  = mosi_q;
endmodule

// File: doc/spi_master_tx.md
# spi_master_tx

Wishbone-side SPI master that originates single register-access frames for the board's SPI register bridge. It is the initiator end of the bridge protocol. It serialises a control byte, a 16-bit address and the write data onto MOSI, or captures read data from MISO. It sits in the host-emulation / loopback-test FPGA image, driven by a local command port and clocked from the system clock.

## Interface
- `CLK_DIV`, default 4: SCLK half-period in `wb_clk_i` cycles; legal range 2..255.
- `wb_clk_i` input 1: system clock; all logic runs on it.
- `wb_rst_i` input 1: reset; asynchronous and active-high.
- `cmd_start` input 1: one-cycle request to launch a frame; sampled only in IDLE.
- `cmd_wrn` input 1: 1 = write frame, 0 = read frame.
- `cmd_select` input 4: byte-lane select; only the `system_includes.vh` codes `WB_FULL_WORD`, `WB_UPPER_HALF_WORD`, `WB_LOWER_HALF_WORD` and `WB_BYTE_0`..`WB_BYTE_3` are legal.
- `cmd_address` input 19: target byte address.
- `cmd_wdata` input 32: write data, lane-aligned.
- `busy` output 1: high from the accepted start until `done`.
- `done` output 1: one-cycle pulse at frame completion.
- `error` output 1: one-cycle pulse when a start is rejected for an illegal select.
- `rdata` output 32: lane-aligned read result; unused lanes are 0.
- `sclk` output 1: SPI clock; idles low.
- `nss` output 1: active-low chip select.
- `mosi` output 1: serial data to the slave.
- `miso` input 1: serial data from the slave.

## Operation
- The block latches `cmd_*` on the accepted `cmd_start`. Input changes afterwards are ignored.
- Lane size N, in bytes, is set by the select code:
  - `WB_FULL_WORD`: N = 4, lanes [31:0].
  - Half-word codes: N = 2. Upper uses [31:16]; lower uses [15:0].
  - `WB_BYTE_k`: N = 1, lane [8k+7:8k].
- Frame bits are numbered from 0 and sent MSB first:
  - Bits 0-7: control byte {wrn, select[3:0], address[18:16]}.
  - Bits 8-15: address[15:8].
  - Bits 16-23: address[7:0].
- Write frame: bits 24..24+8N-1 carry the selected lane MSB first, followed by 8 dummy bits of 0. Total length is 32+8N bits.
- Read frame: bits 24..31 are dummy, with MOSI = 0. The frame runs 32+8N bits in total, and MOSI is 0 after bit 23.
- Read capture:
  - MISO is sampled on the falling SCLK edge ending frame bit 31, and on each following falling edge, for 8N samples.
  - Samples are shifted MSB first into the selected lane of `rdata`.
  - `rdata` updates only at `done`; it holds its previous value during a frame.
- State machine:
  - IDLE: `cmd_start` with a legal select goes to SETUP. An illegal select pulses `error` and stays in IDLE.
  - SETUP: `nss` low and `mosi` = bit 0 for one half-period, then go to SHIFT.
  - SHIFT: per bit, a low half-period with `mosi` stable, then a high half-period. `mosi` changes only on the falling edge. After the last bit's high phase, `sclk` falls and the state goes to HOLD.
  - HOLD: `sclk` low, `nss` low for one half-period, then `nss` high and go to GAP.
  - GAP: `nss` high for 2 half-periods, then pulse `done`, clear `busy` and go to IDLE.
- Counters:
  - Half-period prescaler: 8 bits, wrapping at CLK_DIV-1.
  - Bit counter: 6 bits, maximum 63; the longest frame is 64 bits.
  - Frame length is 32+8N in both directions.
- A `cmd_start` while busy is ignored, with no queueing and no `error`.

## Timing
- Reset values: `busy`=0, `done`=0, `error`=0, `rdata`=0, `sclk`=0, `nss`=1, `mosi`=0; state IDLE.
- Reset asserted mid-frame: outputs take their reset values immediately (asynchronously), the frame is abandoned, and no `done` is issued.
- `busy` rises on the clock edge after the accepted `cmd_start`.
- Start-to-`done` latency is exactly (1 + 2·(32+8N) + 1 + 2)·CLK_DIV + 1 `wb_clk_i` cycles.
- `error` fires on the clock edge after `cmd_start`. `busy` stays 0.
- A new `cmd_start` may be accepted in the cycle `done` is high, since the state is already IDLE that cycle.
- `sclk`, `nss` and `mosi` are registered outputs, so there are no glitches.

## Test plan
- Write full word, CLK_DIV=4, addr 0x12344, wdata 0xDEADBEEF.
  - Required MOSI: control byte {1, `WB_FULL_WORD`, 3'b001}, then 0x23, 0x44, DE AD BE EF, 00.
  - 64 SCLK rising edges; `done` exactly at the latency formula.
- Read `WB_BYTE_2`, addr 0x00010, slave model returns 0xA5 on the MISO schedule above.
  - Required: 40 SCLK edges, `rdata` = 0x00A50000.
- Read `WB_LOWER_HALF_WORD`, MISO driving pattern 0xC3C3.
  - Required: `rdata` = 0x0000C3C3.
- Illegal select 4'hA with `cmd_start`.
  - Required: one-cycle `error`, `nss` stays 1, `busy` stays 0.
- Assert `wb_rst_i` at frame bit 20, then release and issue a new write.
  - Required: `nss`=1, `sclk`=0 in the same cycle as reset; no `done` for the aborted frame; the next frame is correct.
- Loopback against the `spi_slave` bridge.
  - Write 0x0BADF00D to 0x00100, then read it back.
  - Required: the read `rdata` equals the written value, and `cmd_start` pulses during `busy` are ignored.
